// File: rtl/mvm_uart_ctrl.sv
// Command sequencer between the UART byte streams and the matrix-vector multiplier core.
// Optional TX_CHECKSUM_EN appends an XOR checksum byte after the result bytes.
module mvm_uart_ctrl #(
  parameter int R       = 2,
  parameter int C       = 2,
  parameter int W_X     = 4,
  parameter int W_K     = 2,
  parameter int W_Y_OUT = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic [R*C*W_K-1:0]     mvm_k,
  output logic [C*W_X-1:0]       mvm_x,
  output logic                   mvm_start,
  input  logic                   mvm_done,
  input  logic [R*W_Y_OUT-1:0]   mvm_y,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   err
);

  localparam int NK = R * C;
`ifdef TX_CHECKSUM_EN
  localparam int NTX = R + 1;
`else
  localparam int NTX = R;
`endif
  localparam int CW = $clog2(((NK > NTX) ? NK : NTX) + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_LOAD_X, S_START, S_WAIT, S_SEND
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [R*C*W_K-1:0]     k_q;
  logic [C*W_X-1:0]       x_q;
  logic [R*W_Y_OUT-1:0]   y_buf_q;
  logic                   start_q, tx_valid_q, busy_q, err_q;
  logic [7:0]             tx_data_q;

  function automatic logic [7:0] y_byte(input logic [R*W_Y_OUT-1:0] y, input int idx);
    y_byte = 8'(y[idx*W_Y_OUT +: W_Y_OUT]);
  endfunction

`ifdef TX_CHECKSUM_EN
  // Index R selects the checksum byte that trails the results.
  function automatic logic [7:0] tx_byte(input logic [R*W_Y_OUT-1:0] y, input int idx);
    logic [7:0] sum;
    sum = '0;
    for (int i = 0; i < R; i++) sum ^= y_byte(y, i);
    tx_byte = (idx >= R) ? sum : y_byte(y, idx);
  endfunction
`else
  function automatic logic [7:0] tx_byte(input logic [R*W_Y_OUT-1:0] y, input int idx);
    tx_byte = y_byte(y, idx);
  endfunction
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the result buffer is a handful of flops, so it is reset like everything else.
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      x_q        <= '0;
      y_buf_q    <= '0;
      start_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_valid) begin
            if (rx_data == 8'h4B) begin
              state_q <= S_LOAD_K;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else if (rx_data == 8'h58) begin
              state_q <= S_LOAD_X;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_LOAD_K: begin
          if (rx_valid) begin
            k_q[int'(cnt_q)*W_K +: W_K] <= rx_data[W_K-1:0];
            if (cnt_q == CW'(NK - 1)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_LOAD_X: begin
          if (rx_valid) begin
            x_q[int'(cnt_q)*W_X +: W_X] <= rx_data[W_X-1:0];
            if (cnt_q == CW'(C - 1)) state_q <= S_START;
            else                     cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_START: begin
          start_q <= 1'b1;
          err_q   <= rx_valid;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          err_q <= rx_valid;
          // The first result byte is taken straight from the core so it is presented next cycle.
          if (mvm_done) begin
            y_buf_q    <= mvm_y;
            tx_valid_q <= 1'b1;
            tx_data_q  <= tx_byte(mvm_y, 0);
            cnt_q      <= '0;
            state_q    <= S_SEND;
          end
        end
        S_SEND: begin
          err_q <= rx_valid;
          if (tx_valid_q && tx_ready) begin
            if (cnt_q == CW'(NTX - 1)) begin
              tx_valid_q <= 1'b0;
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
            end else begin
              cnt_q     <= cnt_q + 1'b1;
              tx_data_q <= tx_byte(y_buf_q, int'(cnt_q) + 1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mvm_k     = k_q;
  assign mvm_x     = x_q;
  assign mvm_start = start_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Self-checking bench for mvm_uart_ctrl: directed test-plan steps plus randomized runs
// checked against an array/queue model of the command protocol.
module tb_mvm_uart_ctrl;

  localparam int R = 2, C = 2, W_X = 4, W_K = 2, W_Y = 8;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic                 rx_valid = 1'b0;
  logic [7:0]           rx_data = '0;
  logic [R*C*W_K-1:0]   mvm_k;
  logic [C*W_X-1:0]     mvm_x;
  logic                 mvm_start;
  logic                 mvm_done = 1'b0;
  logic [R*W_Y-1:0]     mvm_y = '0;
  logic                 tx_valid;
  logic                 tx_ready = 1'b0;
  logic [7:0]           tx_data;
  logic                 busy;
  logic                 err;

  int total = 0;
  int bad   = 0;

  int         k_ref[R*C];
  int         x_ref[C];
  logic [7:0] kb[R*C];
  logic [7:0] xb[C];
  logic [7:0] exp_q[$];

  mvm_uart_ctrl #(.R(R), .C(C), .W_X(W_X), .W_K(W_K), .W_Y_OUT(W_Y)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .mvm_k(mvm_k), .mvm_x(mvm_x), .mvm_start(mvm_start), .mvm_done(mvm_done),
    .mvm_y(mvm_y), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] k_model();
    longint acc = 0;
    for (int i = 0; i < R*C; i++) acc += longint'(k_ref[i]) * (longint'(1) << (i*W_K));
    return 32'(acc);
  endfunction

  function automatic logic [31:0] x_model();
    longint acc = 0;
    for (int i = 0; i < C; i++) acc += longint'(x_ref[i]) * (longint'(1) << (i*W_X));
    return 32'(acc);
  endfunction

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic do_k();
    send(8'h4B);
    for (int i = 0; i < R*C; i++) begin
      send(kb[i]);
      k_ref[i] = int'(kb[i]) % (1 << W_K);
    end
    check("k_loaded", 32'(mvm_k), k_model());
    check("k_idle", 32'(busy), 32'd0);
  endtask

  // Ends in WAIT, one cycle after the start pulse.
  task automatic do_x();
    send(8'h58);
    for (int i = 0; i < C; i++) begin
      send(xb[i]);
      x_ref[i] = int'(xb[i]) % (1 << W_X);
    end
    check("start_early", 32'(mvm_start), 32'd0);
    check("x_busy", 32'(busy), 32'd1);
    tick();
    check("start_pulse", 32'(mvm_start), 32'd1);
    check("x_loaded", 32'(mvm_x), x_model());
    check("k_kept", 32'(mvm_k), k_model());
    tick();
    check("start_once", 32'(mvm_start), 32'd0);
  endtask

  task automatic expect_result(input logic [R*W_Y-1:0] y);
    int cs = 0;
    for (int i = 0; i < R; i++) begin
      int b = int'(y >> (W_Y*i)) % 256;
      exp_q.push_back(8'(b));
      cs = cs ^ b;
    end
`ifdef TX_CHECKSUM_EN
    exp_q.push_back(8'(cs));
`endif
  endtask

  task automatic do_done(input logic [R*W_Y-1:0] y);
    mvm_y    = y;
    mvm_done = 1'b1;
    tick();
    mvm_done = 1'b0;
    expect_result(y);
    check("tx_first_valid", 32'(tx_valid), 32'd1);
  endtask

  task automatic drain(input bit random_ready);
    for (int cyc = 0; cyc < 200 && exp_q.size() != 0; cyc++) begin
      tx_ready = random_ready ? 1'($urandom_range(1)) : 1'b1;
      check("tx_valid", 32'(tx_valid), 32'd1);
      check("tx_data", 32'(tx_data), 32'(exp_q[0]));
      if (tx_ready) void'(exp_q.pop_front());
      tick();
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tx_ready = 1'b0;
    check("tx_end_valid", 32'(tx_valid), 32'd0);
    check("tx_end_busy", 32'(busy), 32'd0);
  endtask

  task automatic model_reset();
    foreach (k_ref[i]) k_ref[i] = 0;
    foreach (x_ref[i]) x_ref[i] = 0;
  endtask

  initial begin
    model_reset();
    // Reset held with traffic on rx.
    rstn = 1'b0; rx_valid = 1'b1; rx_data = 8'h4B;
    repeat (3) tick();
    check("rst_k", 32'(mvm_k), 32'd0);
    check("rst_x", 32'(mvm_x), 32'd0);
    check("rst_start", 32'(mvm_start), 32'd0);
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_txd", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rx_valid = 1'b0; rstn = 1'b1;
    tick();

    // Directed load/compute with backpressure on the first byte.
    kb = '{8'h01, 8'h03, 8'h02, 8'h01};
    do_k();
    xb = '{8'h05, 8'h0E};
    do_x();
    check("x_e5", 32'(mvm_x), 32'hE5);
    do_done(16'hFE07);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(tx_valid), 32'd1);
      check("bp_data", 32'(tx_data), 32'h07);
      tick();
    end
    tx_ready = 1'b1;
    check("bp_rel_data", 32'(tx_data), 32'h07);
    tick();
    check("b1_valid", 32'(tx_valid), 32'd1);
    check("b1_data", 32'(tx_data), 32'hFE);
    tick();
`ifdef TX_CHECKSUM_EN
    check("cs_valid", 32'(tx_valid), 32'd1);
    check("cs_data", 32'(tx_data), 32'hF9);
    tick();
`endif
    tx_ready = 1'b0;
    exp_q.delete();
    check("dir_end_valid", 32'(tx_valid), 32'd0);
    check("dir_end_busy", 32'(busy), 32'd0);

    // Bad command in IDLE.
    send(8'h41);
    check("badcmd_err", 32'(err), 32'd1);
    check("badcmd_idle", 32'(busy), 32'd0);
    tick();
    check("badcmd_err_clr", 32'(err), 32'd0);

    // Overrun in WAIT; 'K' must be dropped.
    xb = '{8'($urandom), 8'($urandom)};
    do_x();
    send(8'h4B);
    check("ovr_err", 32'(err), 32'd1);
    check("ovr_busy", 32'(busy), 32'd1);
    check("ovr_txv", 32'(tx_valid), 32'd0);
    tick();
    check("ovr_err_clr", 32'(err), 32'd0);
    do_done(16'($urandom));
    drain(1'b1);
    check("ovr_k_kept", 32'(mvm_k), k_model());

    // rx strobe coinciding with mvm_done in WAIT.
    xb = '{8'($urandom), 8'($urandom)};
    do_x();
    mvm_y = 16'($urandom); mvm_done = 1'b1; rx_valid = 1'b1; rx_data = 8'h58;
    tick();
    mvm_done = 1'b0; rx_valid = 1'b0;
    expect_result(mvm_y);
    check("sim_err", 32'(err), 32'd1);
    check("sim_txv", 32'(tx_valid), 32'd1);
    drain(1'b0);

    // Reset in the middle of a K load.
    send(8'h4B);
    send(8'h01);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    model_reset();
    check("midrst_k", 32'(mvm_k), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    xb = '{8'($urandom), 8'($urandom)};
    do_x();
    do_done(16'($urandom));
    drain(1'b1);

    // K reuse after a full run.
    kb = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    do_k();
    xb = '{8'h03, 8'h04};
    do_x();
    check("reuse_x43", 32'(mvm_x), 32'h43);
    do_done(16'($urandom));
    drain(1'b0);

    // Reset with a tx byte pending.
    xb = '{8'($urandom), 8'($urandom)};
    do_x();
    do_done(16'hA5C3);
    exp_q.delete();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    model_reset();
    check("txrst_valid", 32'(tx_valid), 32'd0);
    check("txrst_data", 32'(tx_data), 32'd0);
    check("txrst_busy", 32'(busy), 32'd0);
    check("txrst_k", 32'(mvm_k), 32'd0);

    // Randomized runs.
    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(1) == 1) begin
        for (int i = 0; i < R*C; i++) kb[i] = 8'($urandom);
        do_k();
      end
      for (int i = 0; i < C; i++) xb[i] = 8'($urandom);
      do_x();
      repeat ($urandom_range(3)) tick();
      do_done(16'($urandom));
      drain(1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
